board_row_fetch_sched: RTL and testbench
========================================

Name: board_row_fetch_sched

Overview:
- Scheduler between the VGA scan and the shared chess-board state RAM.
- During horizontal blanking it prefetches the 8 piece codes for the next rank over a req/gnt port into a shadow line buffer, and swaps that buffer in at line start.
- During active video it emits the current square's piece code and the sprite ROM address (row-major within one SQ×SQ sprite).
- Sits upstream of the per-piece sprite ROM/palette units, which read on negedge vga_clk.

Parameters:
- SQ, 55, square/sprite edge in pixels; SQ*SQ must not exceed 4096.
- ORG_X, 100, board left edge in DrawX.
- ORG_Y, 20, board top edge in DrawY.
- H_TRIG, 640, DrawX value that starts the prefetch.
- H_LAST, 799, last DrawX of a line.
- V_LAST, 524, last DrawY of a frame.
- TMO, 64, wait-cycle limit (only with the optional feature).

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- Reset  in  1  asynchronous, active-high reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel line.
- blank  in  1  high = active video.
- brd_req  out  1  board RAM read request.
- brd_addr  out  6  square index, rank*8+file.
- brd_gnt  in  1  grant; brd_rdata is valid in the same cycle.
- brd_rdata  in  4  piece code: 0 = empty, bit3 = black, [2:0] = type.
- piece_code  out  4  piece at the current pixel; 0 outside the board.
- rom_address  out  12  y_in_sq*SQ + x_in_sq.
- in_board  out  1  pixel lies inside the 8×8 board.
- sq_dark  out  1  (rank+file) is odd.
- busy  out  1  FSM is not IDLE.
- err_overrun  out  1  sticky; a swap was missed.

Behaviour:
- Reset (asynchronous) clears:
  - all outputs to 0;
  - FSM to IDLE;
  - both line buffers to 0;
  - all counters to 0.
- Reset mid-fetch aborts the fetch, and brd_req drops immediately.
- Next-line target: NY = (DrawY==V_LAST) ? 0 : DrawY+1.
  - Fetch is needed when ORG_Y <= NY < ORG_Y+8*SQ and NY is the first line of a rank.
  - Rank and y_in_sq are tracked by incremental counters; no dividers.
- FSM states: IDLE -> REQ -> DONE -> IDLE.
  - IDLE: at a posedge with DrawX==H_TRIG and a fetch needed, set file=0 and go to REQ.
  - REQ: brd_req=1 and brd_addr={rank_next, file}. Both hold stable until brd_gnt is sampled high.
  - On gnt, brd_rdata is written to shadow[file] and file increments. Back-to-back grants are allowed, with req staying high.
  - After the 8th gnt, go to DONE; brd_req drops the next cycle.
  - DONE: hold pend_swap=1 and return to IDLE.
- Swap: at a posedge with DrawX==H_LAST:
  - If a fetch was needed and pend_swap=1: shadow is copied to live and pend_swap clears.
  - If a fetch was needed but the FSM is still in REQ:
    - no swap;
    - the live buffer is zeroed (the rank renders empty);
    - err_overrun sets;
    - the fetch is aborted to IDLE.
  - The trigger and the swap can never coincide (H_TRIG < H_LAST).
- Pixel path, 1-cycle latency from DrawX/DrawY to all pixel outputs:
  - x_in_sq and file counters reset at DrawX==ORG_X.
  - x_in_sq wraps at SQ-1; when it wraps, file increments.
  - rom_address = line_base + x_in_sq, where line_base = y_in_sq*SQ is accumulated per line.
- Outside the board, or when blank=0:
  - piece_code = 0, in_board = 0, rom_address = 0.
- err_overrun clears only on Reset.

Optional Feature:
- Macro: SCHED_TIMEOUT_EN.
- With the macro:
  - a wait counter increments in REQ on every cycle without gnt and clears on each gnt;
  - when it reaches TMO, the FSM aborts to IDLE and the remaining shadow entries are written as 0;
  - pend_swap is set (a partial rank is shown) and err_overrun sets.
- Without the macro: REQ waits indefinitely until the H_LAST overrun rule applies.

Decomposition:
- Package board_pkg holds:
  - piece code enum (EMPTY, PAWN..KING, BLACK bit);
  - FSM state typedef;
  - SQ default;
  - BOARD_N = 8.
- Natural sub-module: board_line_buf. It holds the 8×4 shadow and live registers, with write port, swap, clear and a file-indexed read.

Test Plan:
- Reset asserted mid-REQ, at file=3 -> brd_req falls asynchronously; busy=0, piece_code=0, both buffers read 0.
- brd_gnt tied high, DrawY=19, DrawX=640 -> 8 consecutive grants with brd_addr 0..7. At DrawY=20, DrawX=ORG_X, one cycle later: piece_code = rdata[0] and rom_address = 0.
- Same line with grants delayed 30 cycles each (>159 total) -> at DrawX=799: err_overrun=1; rank 0 renders piece_code=0 across DrawX 100..539.
- Within rank 0 at DrawY=21, DrawX=156 -> after 1 cycle: rom_address = 1*55+1 = 56, sq_dark=1 (file 1), in_board=1.
- DrawX=99 or DrawX=540, or blank=0 on any line -> in_board=0, piece_code=0, rom_address=0.
- SCHED_TIMEOUT_EN with TMO=64 and gnt withheld after file 5 -> after 64 cycles: shadow[5..7]=0, the swap occurs, err_overrun=1.

Source files
------------

// File: rtl/board_pkg.sv
// board_pkg: shared piece codes, FSM state and board geometry for the row fetch scheduler.
package board_pkg;
    localparam int BOARD_N = 8;
    localparam int SQ_DEF = 55;

    typedef enum logic [3:0] {
        EMPTY  = 4'd0,
        PAWN   = 4'd1,
        KNIGHT = 4'd2,
        BISHOP = 4'd3,
        ROOK   = 4'd4,
        QUEEN  = 4'd5,
        KING   = 4'd6,
        BLACK  = 4'd8
    } piece_t;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
endpackage

// File: rtl/board_line_buf.sv
// board_line_buf: 8-entry shadow (being fetched) and live (being displayed) piece-code buffers.
module board_line_buf
    import board_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_idx,
    input  logic [3:0] wr_data,
    input  logic       clr_shadow,
    input  logic       clr_live,
    input  logic       swap,
    input  logic [2:0] rd_idx,
    output logic [3:0] rd_data
);
    logic [3:0] shadow [BOARD_N];
    logic [3:0] live [BOARD_N];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            shadow <= '{default: '0};
            live <= '{default: '0};
        end else begin
            for (int i = 0; i < BOARD_N; i++) begin
                if (clr_shadow) shadow[i] <= '0;
                else if (wr_en && wr_idx == 3'(i)) shadow[i] <= wr_data;
                if (clr_live) live[i] <= '0;
                else if (swap) live[i] <= shadow[i];
            end
        end

    assign rd_data = live[rd_idx];
endmodule

// File: rtl/board_row_fetch_sched.sv
// board_row_fetch_sched: prefetches the next rank in h-blank and drives per-pixel piece/sprite address.
// Define SCHED_TIMEOUT_EN to abort a stalled fetch after TMO grant-less cycles.
module board_row_fetch_sched
    import board_pkg::*;
#(
    parameter int SQ     = SQ_DEF,
    parameter int ORG_X  = 100,
    parameter int ORG_Y  = 20,
    parameter int H_TRIG = 640,
    parameter int H_LAST = 799,
    parameter int V_LAST = 524,
    parameter int TMO    = 64
) (
    input  logic        vga_clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    output logic        brd_req,
    output logic [5:0]  brd_addr,
    input  logic        brd_gnt,
    input  logic [3:0]  brd_rdata,
    output logic [3:0]  piece_code,
    output logic [11:0] rom_address,
    output logic        in_board,
    output logic        sq_dark,
    output logic        busy,
    output logic        err_overrun
);
`ifdef SCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    state_t      state, state_n;
    logic [9:0]  ny;
    logic        first_row, need_fetch, at_trig, at_last, grant, start, timeout, overrun, do_swap;
    logic [2:0]  rank_next, frank, ffile, cur_rank, pf, cf;
    logic [11:0] cur_y, cur_base, xs, cx;
    logic        cur_rows, pend_swap, inb;
    logic [15:0] wcnt;
    logic [3:0]  live_code;

    // cur_* describe the line currently on DrawY; they advance at each H_LAST.
    always_comb begin
        ny = (DrawY == 10'(V_LAST)) ? '0 : DrawY + 10'd1;
        first_row = ny == 10'(ORG_Y);
        need_fetch = first_row || (cur_rows && cur_y == 12'(SQ - 1) && cur_rank != 3'(BOARD_N - 1));
        rank_next = first_row ? '0 : cur_rank + 3'd1;
        at_trig = DrawX == 10'(H_TRIG);
        at_last = DrawX == 10'(H_LAST);
        grant = state == REQ && brd_gnt;
        start = state == IDLE && at_trig && need_fetch;
        overrun = state == REQ && at_last && need_fetch;
        timeout = TMO_EN && state == REQ && !brd_gnt && wcnt == 16'(TMO - 1) && !overrun;
        do_swap = at_last && need_fetch && (pend_swap || state == DONE);
        state_n = start ? REQ
                : (overrun || timeout) ? IDLE
                : (grant && ffile == 3'(BOARD_N - 1)) ? DONE
                : (state == DONE) ? IDLE : state;
        brd_req = state == REQ;
        busy = state != IDLE;
        brd_addr = {frank, ffile};
    end

    always_ff @(posedge vga_clk or posedge Reset)
        if (Reset) begin
            state <= IDLE;
            frank <= '0;
            ffile <= '0;
            pend_swap <= 1'b0;
            err_overrun <= 1'b0;
            wcnt <= '0;
        end else begin
            state <= state_n;
            frank <= start ? rank_next : frank;
            ffile <= start ? '0 : grant ? ffile + 3'd1 : ffile;
            pend_swap <= (start || do_swap) ? 1'b0 : (state == DONE || timeout) ? 1'b1 : pend_swap;
            err_overrun <= err_overrun || overrun || timeout;
            wcnt <= (state == REQ && !brd_gnt) ? wcnt + 16'd1 : '0;
        end

    // Shadow is cleared at fetch start so a timed-out fetch leaves unfetched files empty.
    board_line_buf u_buf (
        .clk        (vga_clk),
        .rst        (Reset),
        .wr_en      (grant),
        .wr_idx     (ffile),
        .wr_data    (brd_rdata),
        .clr_shadow (start),
        .clr_live   (overrun),
        .swap       (do_swap),
        .rd_idx     (cf),
        .rd_data    (live_code)
    );

    always_comb begin
        cx = (DrawX == 10'(ORG_X)) ? '0 : xs;
        cf = (DrawX == 10'(ORG_X)) ? '0 : pf;
        inb = blank && cur_rows && DrawX >= 10'(ORG_X) && DrawX < 10'(ORG_X + BOARD_N * SQ);
    end

    always_ff @(posedge vga_clk or posedge Reset)
        if (Reset) begin
            xs <= '0;
            pf <= '0;
            cur_rows <= 1'b0;
            cur_y <= '0;
            cur_base <= '0;
            cur_rank <= '0;
            piece_code <= EMPTY;
            rom_address <= '0;
            in_board <= 1'b0;
            sq_dark <= 1'b0;
        end else begin
            xs <= (cx == 12'(SQ - 1)) ? '0 : cx + 12'd1;
            pf <= (cx == 12'(SQ - 1)) ? cf + 3'd1 : cf;
            if (at_last) begin
                cur_rows <= first_row || (cur_rows && !(cur_y == 12'(SQ - 1) && cur_rank == 3'(BOARD_N - 1)));
                cur_y <= (first_row || cur_y == 12'(SQ - 1)) ? '0 : cur_y + 12'd1;
                cur_base <= (first_row || cur_y == 12'(SQ - 1)) ? '0 : cur_base + 12'(SQ);
                cur_rank <= first_row ? '0 : (cur_y == 12'(SQ - 1)) ? cur_rank + 3'd1 : cur_rank;
            end
            piece_code <= inb ? live_code : EMPTY;
            rom_address <= inb ? cur_base + cx : '0;
            in_board <= inb;
            sq_dark <= inb && (cur_rank[0] ^ cf[0]);
        end
endmodule

// File: tb/tb_board_row_fetch_sched.sv
// tb_board_row_fetch_sched: directed scoreboard bench for board_row_fetch_sched.
// Timeout steps are built only when SCHED_TIMEOUT_EN is defined.
module tb_board_row_fetch_sched;
    typedef struct packed {
        logic [3:0]  pc;
        logic [11:0] rom;
        logic        inb;
        logic        dark;
    } pix_t;

    logic        vga_clk = 1'b0;
    logic        Reset, blank, brd_req, brd_gnt, in_board, sq_dark, busy, err_overrun;
    logic [9:0]  DrawX, DrawY;
    logic [5:0]  brd_addr;
    logic [3:0]  brd_rdata, piece_code;
    logic [11:0] rom_address;
    logic [3:0]  ram [64];
    logic [3:0]  live_m [8];
    int          tests = 0, fails = 0;
    int          gnt_left = 0, gnt_dly = 0, wait_cnt = 0;
    int          got_addr [$];
    int          exp_addr [$];
    pix_t        pix_q [$];

    board_row_fetch_sched dut (
        .vga_clk     (vga_clk),
        .Reset       (Reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .brd_req     (brd_req),
        .brd_addr    (brd_addr),
        .brd_gnt     (brd_gnt),
        .brd_rdata   (brd_rdata),
        .piece_code  (piece_code),
        .rom_address (rom_address),
        .in_board    (in_board),
        .sq_dark     (sq_dark),
        .busy        (busy),
        .err_overrun (err_overrun)
    );

    assign brd_rdata = ram[brd_addr];
    always #5 vga_clk = ~vga_clk;

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Board RAM responder: grants after gnt_dly idle request cycles, up to gnt_left grants.
    initial begin
        brd_gnt = 1'b0;
        forever begin
            tick();
            if (brd_req && gnt_left > 0 && wait_cnt >= gnt_dly) begin
                brd_gnt = 1'b1;
                gnt_left--;
                wait_cnt = 0;
                got_addr.push_back(int'(brd_addr));
            end else begin
                brd_gnt = 1'b0;
                wait_cnt = brd_req ? wait_cnt + 1 : 0;
            end
        end
    end

    function automatic pix_t model(input int x, input int y, input logic b);
        pix_t p;
        int f, r;
        p = '0;
        if (b && y >= 20 && y < 20 + 8 * 55 && x >= 100 && x < 540) begin
            f = (x - 100) / 55;
            r = (y - 20) / 55;
            p.inb = 1'b1;
            p.pc = live_m[f];
            p.rom = 12'(((y - 20) % 55) * 55 + (x - 100) % 55);
            p.dark = 1'((r + f) % 2);
        end
        return p;
    endfunction

    task automatic drive(input int x0, input int x1);
        for (int x = x0; x <= x1; x++) begin
            DrawX = 10'(x);
            tick();
        end
    endtask

    task automatic px(input int x);
        pix_t e;
        pix_q.push_back(model(x, int'(DrawY), blank));
        DrawX = 10'(x);
        tick();
        e = pix_q.pop_front();
        chk("piece_code", 32'(piece_code), 32'(e.pc));
        chk("rom_address", 32'(rom_address), 32'(e.rom));
        chk("in_board", 32'(in_board), 32'(e.inb));
        chk("sq_dark", 32'(sq_dark), 32'(e.dark));
    endtask

    task automatic scan(input int y, input logic b);
        DrawY = 10'(y);
        blank = b;
        for (int x = 0; x <= 799; x++) px(x);
    endtask

    initial begin
        Reset = 1'b1;
        blank = 1'b1;
        DrawX = '0;
        DrawY = '0;
        for (int i = 0; i < 64; i++) ram[i] = 4'((i * 7 + 3) % 16);
        for (int i = 0; i < 8; i++) live_m[i] = '0;
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        chk("rst_req", 32'(brd_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_overrun), 0);
        chk("rst_piece", 32'(piece_code), 0);
        chk("rst_rom", 32'(rom_address), 0);
        chk("rst_inb", 32'(in_board), 0);
        chk("rst_addr", 32'(brd_addr), 0);

        // Reset in the middle of a fetch, three files in.
        DrawY = 10'd19;
        gnt_left = 3;
        gnt_dly = 0;
        drive(636, 645);
        chk("mid_busy", 32'(busy), 1);
        chk("mid_req", 32'(brd_req), 1);
        chk("mid_addr", 32'(brd_addr), 3);
        #3 Reset = 1'b1;
        #1;
        chk("arst_req", 32'(brd_req), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_piece", 32'(piece_code), 0);
        for (int i = 0; i < 8; i++) begin
            chk("arst_shadow", 32'(dut.u_buf.shadow[i]), 0);
            chk("arst_live", 32'(dut.u_buf.live[i]), 0);
        end
        tick();
        Reset = 1'b0;
        got_addr.delete();

        // Full fetch with grant always available, then render rank 0.
        gnt_left = 8;
        for (int i = 0; i < 8; i++) exp_addr.push_back(i);
        drive(630, 798);
        chk("fetch_busy", 32'(busy), 0);
        chk("grant_count", 32'(got_addr.size()), 8);
        while (got_addr.size() > 0 && exp_addr.size() > 0)
            chk("brd_addr", 32'(got_addr.pop_front()), 32'(exp_addr.pop_front()));
        exp_addr.delete();
        got_addr.delete();
        drive(799, 799);
        chk("no_overrun", 32'(err_overrun), 0);
        for (int i = 0; i < 8; i++) live_m[i] = ram[i];
        scan(20, 1'b1);
        scan(21, 1'b1);
        scan(22, 1'b0);

        // Slow grants miss the swap: rank renders empty and err_overrun latches.
        DrawY = 10'd19;
        blank = 1'b1;
        gnt_left = 8;
        gnt_dly = 30;
        drive(630, 799);
        chk("ovr_err", 32'(err_overrun), 1);
        chk("ovr_busy", 32'(busy), 0);
        chk("ovr_partial", 32'(got_addr.size() < 8), 1);
        for (int i = 0; i < got_addr.size(); i++) chk("ovr_addr", 32'(got_addr[i]), 32'(i));
        got_addr.delete();
        gnt_left = 0;
        gnt_dly = 0;
        for (int i = 0; i < 8; i++) live_m[i] = '0;
        scan(20, 1'b1);
        chk("err_sticky", 32'(err_overrun), 1);

`ifdef SCHED_TIMEOUT_EN
        // Grants stop after file 5; timeout shows a partial rank.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        DrawY = 10'd19;
        gnt_left = 5;
        drive(630, 720);
        chk("tmo_busy", 32'(busy), 0);
        chk("tmo_err", 32'(err_overrun), 1);
        for (int i = 5; i < 8; i++) chk("tmo_shadow", 32'(dut.u_buf.shadow[i]), 0);
        drive(721, 799);
        for (int i = 0; i < 8; i++) live_m[i] = (i < 5) ? ram[i] : 4'd0;
        scan(20, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
